// File: rtl/hamming_scrub_ctrl.sv
// Hamming(7,4) codeword store controller.
// Serialises one host port (read / write / error-inject) with a background
// scrubber that walks every address, repairs single-bit errors and writes the
// corrected codeword back. Codeword vector bit i holds position i+1:
// positions 1..7 = p1, p2, d0, p3, d1, d2, d3.
module hamming_scrub_ctrl #(
    parameter int DEPTH          = 16,
    parameter int AW             = 4,
    parameter int SCRUB_INTERVAL = 64,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    input  logic [1:0]       cmd,
    input  logic [AW-1:0]    addr,
    input  logic [3:0]       d_in,
    input  logic [6:0]       error_input_pin,
    output logic             ack,
    output logic [3:0]       d_out,
    output logic [2:0]       err_pos,
    input  logic             scrub_en,
    output logic             scrub_busy,
    output logic [CNT_W-1:0] corr_cnt
);

    localparam logic [1:0] CMD_READ   = 2'b00;
    localparam logic [1:0] CMD_WRITE  = 2'b01;
    localparam logic [1:0] CMD_INJECT = 2'b10;

    localparam int IW = (SCRUB_INTERVAL > 2) ? $clog2(SCRUB_INTERVAL) : 1;
    localparam logic [IW-1:0] IVL_LAST = IW'(SCRUB_INTERVAL - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOST_OP  = 2'd1,
        SCRUB_RD = 2'd2,
        SCRUB_WB = 2'd3
    } state_t;

    // Build a codeword from 4 data bits.
    function automatic logic [6:0] f_encode(input logic [3:0] d);
        logic p1, p2, p3;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p3 = d[1] ^ d[2] ^ d[3];
        return {d[3], d[2], d[1], p3, d[0], p2, p1};
    endfunction

    // Syndrome {s3,s2,s1}: the position of a single flipped bit, 0 when clean.
    function automatic logic [2:0] f_syndrome(input logic [6:0] cw);
        logic s1, s2, s3;
        s1 = cw[0] ^ cw[2] ^ cw[4] ^ cw[6];
        s2 = cw[1] ^ cw[2] ^ cw[5] ^ cw[6];
        s3 = cw[3] ^ cw[4] ^ cw[5] ^ cw[6];
        return {s3, s2, s1};
    endfunction

    // Extract data and flip the bit the syndrome points at; parity-position
    // syndromes (1, 2, 4) leave the data untouched.
    function automatic logic [3:0] f_correct(input logic [6:0] cw, input logic [2:0] syn);
        logic [3:0] data;
        data = {cw[6], cw[5], cw[4], cw[2]};
        case (syn)
            3'd3:    data[0] = ~data[0];
            3'd5:    data[1] = ~data[1];
            3'd6:    data[2] = ~data[2];
            3'd7:    data[3] = ~data[3];
            default: data = data;
        endcase
        return data;
    endfunction

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_host_ph;
    logic [6:0]        r_mem [DEPTH];

    logic [1:0]        r_cmd_p0;
    logic [AW-1:0]     r_addr_p0;
    logic [3:0]        r_din_p0;
    logic [6:0]        r_mask_p0;
    logic [6:0]        r_cw_p1;
    logic [3:0]        r_fix_p1;

    logic              r_ack;
    logic [3:0]        r_d_out;
    logic [2:0]        r_err_pos;
    logic [AW-1:0]     r_scrub_addr;
    logic [IW-1:0]     r_ivl_cnt;
    logic              r_scrub_pend;
    logic [CNT_W-1:0]  r_corr_cnt;

    logic              w_take_host;
    logic              w_take_scrub;
    logic              w_host_done;
    logic              w_scrub_adv;
    logic              w_scrub_wr;
    logic              w_host_wr;
    logic [6:0]        w_host_wdata;
    logic              w_scrub_busy;

    logic [6:0]        w_scrub_cw;
    logic [2:0]        w_scrub_syn;
    logic [3:0]        w_scrub_fix;
    logic [2:0]        w_host_syn;
    logic [3:0]        w_host_data;

    assign w_scrub_cw   = r_mem[r_scrub_addr];
    assign w_scrub_syn  = f_syndrome(w_scrub_cw);
    assign w_scrub_fix  = f_correct(w_scrub_cw, w_scrub_syn);
    assign w_host_syn   = f_syndrome(r_cw_p1);
    assign w_host_data  = f_correct(r_cw_p1, w_host_syn);
    assign w_scrub_busy = (r_state == SCRUB_RD) || (r_state == SCRUB_WB);

    // Next-state decode and the per-cycle action strobes.
    always_comb begin
        w_state_nxt  = r_state;
        w_take_host  = 1'b0;
        w_take_scrub = 1'b0;
        w_host_done  = 1'b0;
        w_scrub_adv  = 1'b0;
        w_scrub_wr   = 1'b0;
        case (r_state)
            IDLE: begin
                // The cycle ack is high the host may still hold req; ignore it.
                if (!r_ack && req) begin
                    w_take_host = 1'b1;
                    w_state_nxt = HOST_OP;
                end else if (r_scrub_pend) begin
                    w_take_scrub = 1'b1;
                    w_state_nxt  = SCRUB_RD;
                end
            end
            HOST_OP: begin
                if (r_host_ph) begin
                    w_host_done = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            SCRUB_RD: begin
                if (w_scrub_syn != 3'd0) begin
                    w_state_nxt = SCRUB_WB;
                end else begin
                    w_scrub_adv = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            SCRUB_WB: begin
                w_scrub_wr  = 1'b1;
                w_scrub_adv = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Host write-back value for the completing command.
    always_comb begin
        w_host_wr    = 1'b0;
        w_host_wdata = r_cw_p1;
        if (w_host_done) begin
            case (r_cmd_p0)
                CMD_WRITE: begin
                    w_host_wr    = 1'b1;
                    w_host_wdata = f_encode(r_din_p0);
                end
                CMD_INJECT: begin
                    w_host_wr    = 1'b1;
                    w_host_wdata = r_cw_p1 ^ r_mask_p0;
                end
                default: w_host_wr = 1'b0;
            endcase
        end
    end

    // State register; the host op spends a fetch phase then a complete phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_host_ph <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_host_ph <= (r_state == HOST_OP) && !r_host_ph;
        end
    end

    // ---- stage p0: capture host command; stage p1: fetched codeword / scrub fix ----
    always_ff @(posedge clk) begin
        if (w_take_host) begin
            r_cmd_p0  <= cmd;
            r_addr_p0 <= addr;
            r_din_p0  <= d_in;
            r_mask_p0 <= error_input_pin;
        end
        if (r_state == HOST_OP && !r_host_ph) begin
            r_cw_p1 <= r_mem[r_addr_p0];
        end
        if (r_state == SCRUB_RD) begin
            r_fix_p1 <= w_scrub_fix;
        end
    end

    // Codeword array: host writes/injects and scrub write-backs never coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 7'b0;
            end
        end else if (w_host_wr) begin
            r_mem[r_addr_p0] <= w_host_wdata;
        end else if (w_scrub_wr) begin
            r_mem[r_scrub_addr] <= f_encode(r_fix_p1);
        end
    end

    // Host response registers: one-cycle ack with read data and syndrome.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack     <= 1'b0;
            r_d_out   <= 4'b0;
            r_err_pos <= 3'b0;
        end else begin
            r_ack <= w_host_done;
            if (w_host_done) begin
                if (r_cmd_p0 == CMD_READ) begin
                    r_d_out   <= w_host_data;
                    r_err_pos <= w_host_syn;
                end else begin
                    r_d_out   <= 4'b0;
                    r_err_pos <= 3'b0;
                end
            end
        end
    end

    // Scrub pointer and saturating correction counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scrub_addr <= '0;
            r_corr_cnt   <= '0;
        end else begin
            if (w_scrub_adv) begin
                r_scrub_addr <= r_scrub_addr + AW'(1);
            end
            if (w_scrub_wr && (r_corr_cnt != {CNT_W{1'b1}})) begin
                r_corr_cnt <= r_corr_cnt + CNT_W'(1);
            end
        end
    end

    // Interval timer: raises a scrub request every SCRUB_INTERVAL non-scrub cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ivl_cnt    <= '0;
            r_scrub_pend <= 1'b0;
        end else if (!scrub_en) begin
            r_ivl_cnt    <= '0;
            r_scrub_pend <= 1'b0;
        end else begin
            if (w_take_scrub) begin
                r_scrub_pend <= 1'b0;
            end
            if (!w_scrub_busy) begin
                if (r_ivl_cnt == IVL_LAST) begin
                    r_ivl_cnt    <= '0;
                    r_scrub_pend <= 1'b1;
                end else begin
                    r_ivl_cnt <= r_ivl_cnt + IW'(1);
                end
            end
        end
    end

    assign ack        = r_ack;
    assign d_out      = r_d_out;
    assign err_pos    = r_err_pos;
    assign scrub_busy = w_scrub_busy;
    assign corr_cnt   = r_corr_cnt;

endmodule

// File: tb/tb_hamming_scrub_ctrl.sv
// Directed bench for hamming_scrub_ctrl (DEPTH=16, SCRUB_INTERVAL=4, CNT_W=2).
module tb_hamming_scrub_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req;
    logic [1:0] cmd;
    logic [3:0] addr;
    logic [3:0] d_in;
    logic [6:0] error_input_pin;
    logic       ack;
    logic [3:0] d_out;
    logic [2:0] err_pos;
    logic       scrub_en;
    logic       scrub_busy;
    logic [1:0] corr_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    hamming_scrub_ctrl #(
        .DEPTH(16), .AW(4), .SCRUB_INTERVAL(4), .CNT_W(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .cmd(cmd), .addr(addr),
        .d_in(d_in), .error_input_pin(error_input_pin), .ack(ack),
        .d_out(d_out), .err_pos(err_pos), .scrub_en(scrub_en),
        .scrub_busy(scrub_busy), .corr_cnt(corr_cnt)
    );

    task automatic do_reset();
        rst_n = 1'b0; req = 1'b0; cmd = 2'b00; addr = 4'd0; d_in = 4'd0;
        error_input_pin = 7'd0; scrub_en = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Issue one host request, return response and edge count up to ack.
    task automatic host_op(input logic [1:0] c, input logic [3:0] a, input logic [3:0] d,
                           input logic [6:0] m, output logic [3:0] dout,
                           output logic [2:0] ep, output int lat);
        bit got;
        @(negedge clk);
        req = 1'b1; cmd = c; addr = a; d_in = d; error_input_pin = m;
        lat = 0; got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            lat++;
            if (ack) got = 1;
        end
        if (!got) begin
            tests++; fails++;
            $display("FAIL ack_timeout cmd=%b addr=%0d no ack within 20 cycles", c, a);
            lat = -1;
        end
        dout = d_out; ep = err_pos;
        req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [3:0] dout; logic [2:0] ep; int lat;
        rst_n = 1'b0; req = 1'b0; scrub_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (ack !== 1'b0 || scrub_busy !== 1'b0 || corr_cnt !== 2'd0 ||
            d_out !== 4'd0 || err_pos !== 3'd0) begin
            fails++;
            $display("FAIL reset_outputs got ack=%b busy=%b cnt=%0d dout=%b ep=%0d want all 0",
                     ack, scrub_busy, corr_cnt, d_out, err_pos);
        end
        do_reset();
        for (int a = 0; a < 16; a++) begin
            host_op(2'b00, 4'(a), 4'd0, 7'd0, dout, ep, lat);
            tests++;
            if (dout !== 4'd0 || ep !== 3'd0 || lat !== 3) begin
                fails++;
                $display("FAIL reset_read a%0d got dout=%b ep=%0d lat=%0d want 0000/0/3",
                         a, dout, ep, lat);
            end
        end
        tests++;
        if (corr_cnt !== 2'd0) begin
            fails++;
            $display("FAIL reset_corr_cnt got %0d want 0", corr_cnt);
        end
    endtask

    task automatic test_write_read();
        logic [3:0] dout; logic [2:0] ep; int lat;
        host_op(2'b01, 4'd3, 4'b1011, 7'd0, dout, ep, lat);
        host_op(2'b00, 4'd3, 4'd0, 7'd0, dout, ep, lat);
        tests++;
        if (dout !== 4'b1011 || ep !== 3'd0) begin
            fails++;
            $display("FAIL write_read a3 got dout=%b ep=%0d want 1011/0", dout, ep);
        end
    endtask

    task automatic test_inject();
        logic [3:0] dout; logic [2:0] ep; int lat;
        host_op(2'b10, 4'd3, 4'd0, 7'b0000100, dout, ep, lat);
        for (int k = 0; k < 2; k++) begin
            host_op(2'b00, 4'd3, 4'd0, 7'd0, dout, ep, lat);
            tests++;
            if (dout !== 4'b1011 || ep !== 3'd3) begin
                fails++;
                $display("FAIL inject_d0_read%0d got dout=%b ep=%0d want 1011/3", k, dout, ep);
            end
        end
        host_op(2'b10, 4'd5, 4'd0, 7'b0000001, dout, ep, lat);
        host_op(2'b00, 4'd5, 4'd0, 7'd0, dout, ep, lat);
        tests++;
        if (dout !== 4'b0000 || ep !== 3'd1) begin
            fails++;
            $display("FAIL inject_p1 got dout=%b ep=%0d want 0000/1", dout, ep);
        end
        host_op(2'b11, 4'd3, 4'b1111, 7'b1111111, dout, ep, lat);
        tests++;
        if (dout !== 4'b0000 || ep !== 3'd0) begin
            fails++;
            $display("FAIL reserved_resp got dout=%b ep=%0d want 0000/0", dout, ep);
        end
        host_op(2'b00, 4'd3, 4'd0, 7'd0, dout, ep, lat);
        tests++;
        if (dout !== 4'b1011 || ep !== 3'd3) begin
            fails++;
            $display("FAIL reserved_noeffect got dout=%b ep=%0d want 1011/3", dout, ep);
        end
        host_op(2'b01, 4'd7, 4'b0110, 7'd0, dout, ep, lat);
        host_op(2'b10, 4'd7, 4'd0, 7'b1000000, dout, ep, lat);
        host_op(2'b00, 4'd7, 4'd0, 7'd0, dout, ep, lat);
        tests++;
        if (dout !== 4'b0110 || ep !== 3'd7) begin
            fails++;
            $display("FAIL inject_d3 got dout=%b ep=%0d want 0110/7", dout, ep);
        end
        host_op(2'b01, 4'd7, 4'b0110, 7'd0, dout, ep, lat);
        host_op(2'b10, 4'd9, 4'd0, 7'b0000011, dout, ep, lat);
        host_op(2'b00, 4'd9, 4'd0, 7'd0, dout, ep, lat);
        tests++;
        if (dout !== 4'b0001 || ep !== 3'd3) begin
            fails++;
            $display("FAIL double_miscorrect got dout=%b ep=%0d want 0001/3", dout, ep);
        end
        host_op(2'b01, 4'd9, 4'd0, 7'd0, dout, ep, lat);
        tests++;
        if (corr_cnt !== 2'd0) begin
            fails++;
            $display("FAIL host_no_cnt got corr_cnt=%0d want 0", corr_cnt);
        end
    endtask

    task automatic test_scrub();
        logic [3:0] dout; logic [2:0] ep; int lat;
        bit seen_busy;
        seen_busy = 0;
        @(negedge clk);
        scrub_en = 1'b1;
        for (int i = 0; i < 250; i++) begin
            @(posedge clk); #1;
            if (scrub_busy) seen_busy = 1;
        end
        tests++;
        if (seen_busy !== 1'b1) begin
            fails++;
            $display("FAIL scrub_busy_seen got %b want 1", seen_busy);
        end
        tests++;
        if (corr_cnt !== 2'd2) begin
            fails++;
            $display("FAIL scrub_walk_cnt got %0d want 2", corr_cnt);
        end
        host_op(2'b10, 4'd1, 4'd0, 7'b0100000, dout, ep, lat);
        repeat (250) @(posedge clk);
        #1;
        tests++;
        if (corr_cnt !== 2'd3) begin
            fails++;
            $display("FAIL scrub_wrap_cnt got %0d want 3", corr_cnt);
        end
        @(negedge clk);
        scrub_en = 1'b0;
        repeat (4) @(posedge clk);
        host_op(2'b00, 4'd3, 4'd0, 7'd0, dout, ep, lat);
        tests++;
        if (dout !== 4'b1011 || ep !== 3'd0) begin
            fails++;
            $display("FAIL scrubbed_a3 got dout=%b ep=%0d want 1011/0", dout, ep);
        end
        host_op(2'b00, 4'd5, 4'd0, 7'd0, dout, ep, lat);
        tests++;
        if (dout !== 4'b0000 || ep !== 3'd0) begin
            fails++;
            $display("FAIL scrubbed_a5 got dout=%b ep=%0d want 0000/0", dout, ep);
        end
        host_op(2'b00, 4'd1, 4'd0, 7'd0, dout, ep, lat);
        tests++;
        if (dout !== 4'b0000 || ep !== 3'd0) begin
            fails++;
            $display("FAIL scrubbed_a1 got dout=%b ep=%0d want 0000/0", dout, ep);
        end
    endtask

    task automatic test_host_first();
        int lat; bit got; bit busy_any;
        @(negedge clk);
        scrub_en = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        scrub_en = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        req = 1'b1; cmd = 2'b00; addr = 4'd3; d_in = 4'd0; error_input_pin = 7'd0;
        lat = 0; got = 0; busy_any = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            lat++;
            if (scrub_busy) busy_any = 1;
            if (ack) got = 1;
        end
        tests++;
        if (lat !== 3 || busy_any !== 1'b0 || d_out !== 4'b1011 || err_pos !== 3'd0) begin
            fails++;
            $display("FAIL host_first got lat=%0d busy=%b dout=%b ep=%0d want 3/0/1011/0",
                     lat, busy_any, d_out, err_pos);
        end
        req = 1'b0;
        @(negedge clk);
        scrub_en = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_saturation();
        logic [3:0] dout; logic [2:0] ep; int lat;
        do_reset();
        host_op(2'b10, 4'd2,  4'd0, 7'b0000010, dout, ep, lat);
        host_op(2'b10, 4'd4,  4'd0, 7'b0001000, dout, ep, lat);
        host_op(2'b10, 4'd6,  4'd0, 7'b0010000, dout, ep, lat);
        host_op(2'b10, 4'd8,  4'd0, 7'b1000000, dout, ep, lat);
        host_op(2'b10, 4'd10, 4'd0, 7'b0000100, dout, ep, lat);
        @(negedge clk);
        scrub_en = 1'b1;
        repeat (250) @(posedge clk);
        #1;
        tests++;
        if (corr_cnt !== 2'd3) begin
            fails++;
            $display("FAIL cnt_saturate got %0d want 3", corr_cnt);
        end
        @(negedge clk);
        scrub_en = 1'b0;
        repeat (4) @(posedge clk);
        host_op(2'b00, 4'd8, 4'd0, 7'd0, dout, ep, lat);
        tests++;
        if (dout !== 4'b0000 || ep !== 3'd0) begin
            fails++;
            $display("FAIL sat_a8_clean got dout=%b ep=%0d want 0000/0", dout, ep);
        end
    endtask

    task automatic test_scrub_delay();
        logic [3:0] dout; logic [2:0] ep; int lat;
        bit got; logic busy0, busy1;
        do_reset();
        host_op(2'b10, 4'd0, 4'd0, 7'b0010000, dout, ep, lat);
        scrub_en = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        busy0 = scrub_busy;
        @(negedge clk);
        req = 1'b1; cmd = 2'b00; addr = 4'd4; d_in = 4'd0; error_input_pin = 7'd0;
        lat = 0; got = 0; busy1 = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) busy1 = scrub_busy;
            if (ack) got = 1;
        end
        dout = d_out; ep = err_pos;
        req = 1'b0;
        scrub_en = 1'b0;
        tests++;
        if (busy0 !== 1'b1 || busy1 !== 1'b1) begin
            fails++;
            $display("FAIL delay_busy got rd=%b wb=%b want 1/1", busy0, busy1);
        end
        tests++;
        if (lat !== 5 || dout !== 4'b0000 || ep !== 3'd0) begin
            fails++;
            $display("FAIL delay_lat got lat=%0d dout=%b ep=%0d want 5/0000/0", lat, dout, ep);
        end
        tests++;
        if (corr_cnt !== 2'd1) begin
            fails++;
            $display("FAIL delay_cnt got %0d want 1", corr_cnt);
        end
        repeat (4) @(posedge clk);
    endtask

    task automatic test_reset_mid_op();
        logic [3:0] dout; logic [2:0] ep; int lat;
        bit seen_ack;
        host_op(2'b01, 4'd3, 4'b1011, 7'd0, dout, ep, lat);
        @(negedge clk);
        req = 1'b1; cmd = 2'b01; addr = 4'd10; d_in = 4'b1111; error_input_pin = 7'd0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        req = 1'b0;
        seen_ack = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (ack) seen_ack = 1;
        end
        tests++;
        if (seen_ack !== 1'b0) begin
            fails++;
            $display("FAIL abort_no_ack got ack seen=%b want 0", seen_ack);
        end
        @(negedge clk);
        rst_n = 1'b1;
        host_op(2'b00, 4'd3, 4'd0, 7'd0, dout, ep, lat);
        tests++;
        if (dout !== 4'b0000 || ep !== 3'd0) begin
            fails++;
            $display("FAIL abort_a3_cleared got dout=%b ep=%0d want 0000/0", dout, ep);
        end
        host_op(2'b00, 4'd10, 4'd0, 7'd0, dout, ep, lat);
        tests++;
        if (dout !== 4'b0000 || ep !== 3'd0) begin
            fails++;
            $display("FAIL abort_a10_unwritten got dout=%b ep=%0d want 0000/0", dout, ep);
        end
    endtask

    initial begin
        rst_n = 1'b0; req = 1'b0; cmd = 2'b00; addr = 4'd0; d_in = 4'd0;
        error_input_pin = 7'd0; scrub_en = 1'b0;
        test_reset();
        test_write_read();
        test_inject();
        test_scrub();
        test_host_first();
        test_saturation();
        test_scrub_delay();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
